// File: rtl/barcode_rdr_pkg.sv
// Shared definitions for the barcode reader: FSM encoding and station-ID format.
package barcode_rdr_pkg;

  localparam int unsigned ID_W = 8;
  localparam logic [1:0] ID_PREFIX = 2'b00;

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_START         = 3'd1;
  localparam logic [2:0] S_BIT_LOW       = 3'd2;
  localparam logic [2:0] S_BIT_WAIT_HI   = 3'd3;
  localparam logic [2:0] S_BIT_WAIT_FALL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE          = S_IDLE,
    ST_START         = S_START,
    ST_BIT_LOW       = S_BIT_LOW,
    ST_BIT_WAIT_HI   = S_BIT_WAIT_HI,
    ST_BIT_WAIT_FALL = S_BIT_WAIT_FALL
  } state_t;

endpackage

// File: rtl/barcode_rdr_sync_edge.sv
// 3-flop synchronizer for an asynchronous pin with registered-edge fall/rise strobes.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic synced,
  output logic fall,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the line's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced = sync_q;
  assign fall   = prev_q & ~sync_q;
  assign rise   = ~prev_q & sync_q;

endmodule

// File: rtl/barcode_rdr.sv
// Serial barcode decoder: calibrates the bit period from the start pulse and
// delivers an 8-bit station ID with a sticky valid flag.
module barcode_rdr
  import barcode_rdr_pkg::*;
#(
  parameter int TMR_W = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            BC,
  input  logic            clr_ID_vld,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld,
  output state_t          dbg_state
);

  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic bc_s, bc_fall, bc_rise;
  logic [TMR_W-1:0] period, t_len, tmr, to_tmr;
  logic [2:0]       bit_cnt;
  logic [ID_W-1:0]  shift, shift_nxt;

  logic period_clr, period_inc, t_load, tmr_start, tmr_inc, do_sample, frame_done;
  logic timeout;

  sync_edge #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (BC),
    .synced (bc_s),
    .fall   (bc_fall),
    .rise   (bc_rise)
  );

  assign shift_nxt = {shift[ID_W-2:0], bc_s};
  assign timeout   = (state != ST_IDLE) && (to_tmr == TMR_MAX);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    period_clr = 1'b0;
    period_inc = 1'b0;
    t_load     = 1'b0;
    tmr_start  = 1'b0;
    tmr_inc    = 1'b0;
    do_sample  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bc_fall) begin
          period_clr = 1'b1;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        if (bc_rise) begin
          t_load    = 1'b1;
          state_nxt = ST_BIT_WAIT_FALL;
        end else if (!bc_s) begin
          period_inc = 1'b1;
        end
      end
      ST_BIT_WAIT_FALL: begin
        if (bc_fall) begin
          tmr_start = 1'b1;
          state_nxt = ST_BIT_LOW;
        end
      end
      ST_BIT_LOW: begin
        if (tmr == t_len) begin
          do_sample = 1'b1;
          state_nxt = (bit_cnt == 3'd7) ? ST_IDLE : ST_BIT_WAIT_HI;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_BIT_WAIT_HI: begin
        if (bc_s) state_nxt = ST_BIT_WAIT_FALL;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A stuck line abandons the frame silently, whatever the state was doing.
    if (timeout) begin
      state_nxt = ST_IDLE;
      t_load    = 1'b0;
      do_sample = 1'b0;
    end
  end

  assign frame_done = do_sample && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period  <= '0;
      t_len   <= '0;
      tmr     <= '0;
      to_tmr  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (period_clr)                           period <= TMR_ONE;
      else if (period_inc && period != TMR_MAX) period <= period + TMR_ONE;

      if (t_load) begin
        t_len   <= period;
        bit_cnt <= '0;
      end

      if (tmr_start)                        tmr <= TMR_ONE;
      else if (tmr_inc && tmr != TMR_MAX)   tmr <= tmr + TMR_ONE;

      if (do_sample) begin
        shift   <= shift_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Stuck-line watchdog: restarts on every synced edge, idle while waiting for a frame.
      if (state == ST_IDLE || bc_fall || bc_rise) to_tmr <= '0;
      else if (to_tmr != TMR_MAX)                 to_tmr <= to_tmr + TMR_ONE;
    end
  end

  // Consumer handshake: ID_vld rises with a new ID and holds until a one-cycle
  // clr_ID_vld pulse; a new ID arriving in the same cycle as the clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID     <= '0;
      ID_vld <= 1'b0;
    end else if (frame_done && shift_nxt[ID_W-1:ID_W-2] == ID_PREFIX) begin
      ID     <= shift_nxt;
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end

endmodule
